mem_sram_ctrl: RTL

MEM_SRAM_CTRL -- requirements
Module: mem_sram_ctrl

---
 rtl/mem_sram_ctrl.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/mem_sram_ctrl.sv
// Single-bank SRAM line controller: two-stage request pipeline (strobe, capture)
// feeding an in-order response FIFO, with credit-based request back-pressure.
module mem_sram_ctrl #(
  parameter logic [3:0]  BANK_ID   = 4'd0,
  parameter int unsigned RSP_DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_write,
  input  logic [18:0]  req_addr,
  input  logic [255:0] req_wdata,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [255:0] rsp_data,
  output logic         rsp_err,
  output logic         sram_cs,
  output logic         sram_read,
  output logic         sram_write,
  output logic [3:0]   sram_id,
  output logic [18:0]  sram_addr,
  output logic [255:0] sram_wdata,
  input  logic [255:0] sram_rdata
);

  localparam int unsigned PtrW = $clog2(RSP_DEPTH);
  localparam int unsigned CntW = $clog2(RSP_DEPTH + 1);
  localparam logic [PtrW-1:0] PtrLast  = PtrW'(RSP_DEPTH - 1);
  localparam logic [CntW-1:0] DepthCnt = CntW'(RSP_DEPTH);
  localparam logic [CntW:0]   DepthLim = (CntW + 1)'(RSP_DEPTH);

  // Pipeline and control state
  logic            ready_en_q, ready_en_d;
  logic            s1_rsp_q, s1_rsp_d;   // S1 holds a response-producing request
  logic            s1_err_q, s1_err_d;
  logic            s2_rsp_q, s2_rsp_d;   // S2 pushes into the FIFO this cycle
  logic            s2_err_q, s2_err_d;
  logic            sram_cs_q, sram_cs_d;
  logic            sram_read_q, sram_read_d;
  logic            sram_write_q, sram_write_d;
  logic [18:0]     sram_addr_q, sram_addr_d;
  logic [255:0]    sram_wdata_q, sram_wdata_d;

  // Response FIFO state
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic [255:0]    fifo_data_q [RSP_DEPTH];
  logic            fifo_err_q  [RSP_DEPTH];

  logic            accept, hit, push, pop;
  logic [CntW:0]   used;
  logic [255:0]    push_data;

  // Handshake, credit accounting and FIFO head outputs
  always_comb begin
    used      = {1'b0, count_q} + {{CntW{1'b0}}, s1_rsp_q} + {{CntW{1'b0}}, s2_rsp_q};
    // Pops are not credited until count_q drops, which keeps credits conservative.
    req_ready = ready_en_q && (used < DepthLim);
    accept    = req_valid && req_ready;
    hit       = (req_addr[18:15] == BANK_ID);
    rsp_valid = (count_q != '0);
    pop       = rsp_valid && rsp_ready;
    push      = s2_rsp_q;
    push_data = s2_err_q ? '0 : sram_rdata;
    rsp_data  = rsp_valid ? fifo_data_q[rd_ptr_q] : '0;
    rsp_err   = rsp_valid ? fifo_err_q[rd_ptr_q] : 1'b0;
  end

  // Next-state for the request pipeline and SRAM strobes
  always_comb begin
    ready_en_d   = 1'b1;
    s1_rsp_d     = accept && (!req_write || !hit);
    s1_err_d     = accept && !hit;
    s2_rsp_d     = s1_rsp_q;
    s2_err_d     = s1_err_q;
    sram_cs_d    = accept && hit;
    sram_read_d  = accept && hit && !req_write;
    sram_write_d = accept && hit && req_write;
    sram_addr_d  = sram_addr_q;
    sram_wdata_d = sram_wdata_q;
    if (accept) begin
      sram_addr_d  = req_addr;
      sram_wdata_d = req_wdata;
    end
  end

  // Next-state for FIFO pointers and occupancy
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + 1'b1;
    end
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (!push && pop) begin
      count_d = count_q - 1'b1;
    end
  end

  // Control registers; reset discards everything in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en_q   <= 1'b0;
      s1_rsp_q     <= 1'b0;
      s1_err_q     <= 1'b0;
      s2_rsp_q     <= 1'b0;
      s2_err_q     <= 1'b0;
      sram_cs_q    <= 1'b0;
      sram_read_q  <= 1'b0;
      sram_write_q <= 1'b0;
      sram_addr_q  <= '0;
      sram_wdata_q <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      ready_en_q   <= ready_en_d;
      s1_rsp_q     <= s1_rsp_d;
      s1_err_q     <= s1_err_d;
      s2_rsp_q     <= s2_rsp_d;
      s2_err_q     <= s2_err_d;
      sram_cs_q    <= sram_cs_d;
      sram_read_q  <= sram_read_d;
      sram_write_q <= sram_write_d;
      sram_addr_q  <= sram_addr_d;
      sram_wdata_q <= sram_wdata_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
    end
  end

  // FIFO storage; contents are only meaningful below count_q, so no reset
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data_q[wr_ptr_q] <= push_data;
      fifo_err_q[wr_ptr_q]  <= s2_err_q;
    end
  end

  assign sram_cs    = sram_cs_q;
  assign sram_read  = sram_read_q;
  assign sram_write = sram_write_q;
  assign sram_id    = BANK_ID;
  assign sram_addr  = sram_addr_q;
  assign sram_wdata = sram_wdata_q;

`ifndef SYNTHESIS
  a_no_rd_wr: assert property (@(posedge clk) disable iff (!rst_n)
    !(sram_read && sram_write));
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    (push && !pop) |-> (count_q < DepthCnt));
  a_bank_match: assert property (@(posedge clk) disable iff (!rst_n)
    sram_cs |-> (sram_id == sram_addr[18:15]));
`endif

endmodule
